launch_sequencer: RTL and testbench

//  Sequences one launch of the turret: aim servo, motor spin-up, arm release, cooldown.

---
 rtl/launch_sequencer.sv | 96 +++++++++
 tb/tb_launch_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/launch_sequencer.sv
// launch_sequencer: captures one shot on a fire edge and walks it through aim, spin-up, release and cooldown
module launch_sequencer #(
   parameter int unsigned AIM_CYCLES      = 50_000_000,
   parameter int unsigned SPINUP_CYCLES   = 100_000_000,
   parameter int unsigned RELEASE_CYCLES  = 25_000_000,
   parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
   parameter int unsigned ANGLE_MAX       = 90,
   parameter int unsigned VEL_MAX         = 100
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fire,
   input  logic [31:0] angle,
   input  logic [31:0] velocity,
   input  logic        abort,
   output logic [7:0]  theta_cmd,
   output logic [7:0]  motor_cmd,
   output logic        arm_release,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [2:0]  state
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      AIM      = 3'd1,
      SPINUP   = 3'd2,
      RELEASE  = 3'd3,
      COOLDOWN = 3'd4
   } state_t;
   state_t cur, nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [7:0] vel_l;
   logic fire_q, fire_edge, legal, last, capture, stop;
   assign fire_edge = fire & ~fire_q;
   assign legal     = velocity != 0 && velocity <= VEL_MAX && angle <= ANGLE_MAX;
   assign last      = cnt == '0;
   assign capture   = cur == IDLE && fire_edge && !abort && legal;
   assign stop      = abort && (cur == AIM || cur == SPINUP || cur == RELEASE);
   assign busy      = cur != IDLE;
   assign state     = cur;
   // each state's counter is loaded with N-1 on entry, so the state lasts exactly N cycles
   always_comb begin
      nxt     = cur;
      cnt_nxt = cnt - 32'd1;
      case (cur)
         IDLE: begin
            nxt     = capture ? AIM : IDLE;
            cnt_nxt = AIM_CYCLES - 1;
         end
         AIM: if (last) begin
            nxt     = SPINUP;
            cnt_nxt = SPINUP_CYCLES - 1;
         end
         SPINUP: if (last) begin
            nxt     = RELEASE;
            cnt_nxt = RELEASE_CYCLES - 1;
         end
         RELEASE: if (last) begin
            nxt     = COOLDOWN;
            cnt_nxt = COOLDOWN_CYCLES - 1;
         end
         COOLDOWN: if (last) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (stop) begin
         nxt     = COOLDOWN;
         cnt_nxt = COOLDOWN_CYCLES - 1;
      end
   end
   // fire_q resets high so a fire level held through reset is not seen as an edge
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         cur         <= IDLE;
         cnt         <= '0;
         fire_q      <= 1'b1;
         vel_l       <= '0;
         theta_cmd   <= '0;
         motor_cmd   <= '0;
         arm_release <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         cur    <= nxt;
         cnt    <= cnt_nxt;
         fire_q <= fire;
         if (capture) begin
            theta_cmd <= angle[7:0];
            vel_l     <= velocity[7:0];
         end
         motor_cmd   <= nxt == SPINUP ? vel_l : nxt == RELEASE ? motor_cmd : '0;
         arm_release <= nxt == RELEASE;
         done        <= cur == COOLDOWN && nxt == IDLE;
         err         <= cur == IDLE && fire_edge && !abort && !legal;
      end
endmodule

// File: tb/tb_launch_sequencer.sv
// tb_launch_sequencer: directed scoreboard bench for launch_sequencer with short phase lengths
module tb_launch_sequencer;
   localparam int A = 4, S = 6, R = 3, C = 5, TOTAL = A + S + R + C;
   logic clock = 1'b0, reset, fire, abort;
   logic [31:0] angle, velocity;
   logic [7:0] theta_cmd, motor_cmd;
   logic arm_release, busy, done, err;
   logic [2:0] state;
   typedef struct {string tag; logic [31:0] val;} exp_t;
   exp_t sb[$];
   int vectors = 0, miscompares = 0;
   int arm_seen, arm_cnt, err_seen, done_seen, busy_cnt;
   always #5 clock = ~clock;
   launch_sequencer #(
      .AIM_CYCLES(A), .SPINUP_CYCLES(S), .RELEASE_CYCLES(R), .COOLDOWN_CYCLES(C),
      .ANGLE_MAX(90), .VEL_MAX(100)
   ) dut (
      .clock(clock), .reset(reset), .fire(fire), .angle(angle), .velocity(velocity),
      .abort(abort), .theta_cmd(theta_cmd), .motor_cmd(motor_cmd), .arm_release(arm_release),
      .busy(busy), .done(done), .err(err), .state(state)
   );
   task automatic push_exp(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask
   task automatic check(input logic [31:0] obs);
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: observed %0d with no expected value", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
      arm_seen  |= int'(arm_release);
      arm_cnt   += int'(arm_release);
      err_seen  += int'(err);
      done_seen += int'(done);
      busy_cnt  += int'(busy);
   endtask
   task automatic clear_acc();
      arm_seen = 0; arm_cnt = 0; err_seen = 0; done_seen = 0; busy_cnt = 0;
   endtask
   initial begin
      int motor_k, arm_k, done_k, n;
      logic [7:0] th1;
      logic [2:0] st1;
      reset = 1'b1; fire = 1'b1; abort = 1'b0; angle = '0; velocity = '0;
      #12;
      push_exp("rst_state", 0); push_exp("rst_theta", 0); push_exp("rst_motor", 0);
      push_exp("rst_arm", 0); push_exp("rst_busy", 0); push_exp("rst_done_err", 0);
      check(32'(state)); check(32'(theta_cmd)); check(32'(motor_cmd));
      check(32'(arm_release)); check(32'(busy)); check(32'({done, err}));
      reset = 1'b0;
      tick();
      push_exp("fire_held_through_reset", 0);
      check(32'(state));
      // normal shot: angle 45, velocity 60
      fire = 1'b0;
      tick();
      angle = 45; velocity = 60; fire = 1'b1;
      clear_acc();
      motor_k = 0; arm_k = 0; done_k = 0; th1 = '0; st1 = '0;
      for (int k = 1; k <= TOTAL + 6; k++) begin
         tick();
         if (k == 1) begin th1 = theta_cmd; st1 = state; end
         if (motor_k == 0 && motor_cmd == 8'd60) motor_k = k;
         if (arm_k == 0 && arm_release) arm_k = k;
         if (done_k == 0 && done) done_k = k;
      end
      push_exp("t1_theta", 45); push_exp("t1_state_aim", 1); push_exp("t1_motor_k", A + 1);
      push_exp("t1_arm_k", A + S + 1); push_exp("t1_arm_cycles", R);
      push_exp("t1_busy_cycles", TOTAL); push_exp("t1_done_k", TOTAL + 1);
      push_exp("t1_done_cnt", 1); push_exp("t1_err_cnt", 0); push_exp("t1_motor_end", 0);
      check(32'(th1)); check(32'(st1)); check(motor_k); check(arm_k); check(arm_cnt);
      check(busy_cnt); check(done_k); check(done_seen); check(err_seen); check(32'(motor_cmd));
      // illegal launches
      fire = 1'b0;
      tick();
      angle = 91; velocity = 50; fire = 1'b1;
      tick();
      push_exp("t2a_err", 1); push_exp("t2a_state", 0); push_exp("t2a_theta", 45); push_exp("t2a_motor", 0);
      check(32'(err)); check(32'(state)); check(32'(theta_cmd)); check(32'(motor_cmd));
      tick();
      push_exp("t2a_err_pulse_end", 0);
      check(32'(err));
      fire = 1'b0;
      tick();
      angle = 30; velocity = 0; fire = 1'b1;
      tick();
      push_exp("t2b_err", 1); push_exp("t2b_state", 0); push_exp("t2b_theta", 45);
      check(32'(err)); check(32'(state)); check(32'(theta_cmd));
      fire = 1'b0;
      tick();
      // boundary-legal shot aborted in the third spin-up cycle
      angle = 90; velocity = 100; fire = 1'b1;
      clear_acc();
      tick();
      push_exp("t3_state_aim", 1); push_exp("t3_theta", 90);
      check(32'(state)); check(32'(theta_cmd));
      repeat (A) tick();
      push_exp("t3_state_spin", 2); push_exp("t3_motor", 100);
      check(32'(state)); check(32'(motor_cmd));
      repeat (2) tick();
      push_exp("t3_spin3", 2);
      check(32'(state));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      push_exp("t3_abort_state", 4); push_exp("t3_abort_motor", 0); push_exp("t3_abort_busy", 1);
      check(32'(state)); check(32'(motor_cmd)); check(32'(busy));
      done_seen = 0;
      repeat (C) tick();
      push_exp("t3_done", 1); push_exp("t3_done_cnt", 1); push_exp("t3_state_idle", 0);
      push_exp("t3_arm_seen", 0); push_exp("t3_busy", 0);
      check(32'(done)); check(done_seen); check(32'(state)); check(arm_seen); check(32'(busy));
      // fire toggling while busy, then held high
      fire = 1'b0;
      tick();
      angle = 10; velocity = 20; fire = 1'b1;
      clear_acc();
      tick();
      repeat (A) tick();
      push_exp("t4_state_spin", 2);
      check(32'(state));
      fire = 1'b0; tick();
      fire = 1'b1; tick();
      fire = 1'b0; tick();
      fire = 1'b1; tick();
      n = A + 5;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      push_exp("t4_done_k", TOTAL + 1);
      check(n);
      repeat (5) tick();
      push_exp("t4_state_idle", 0); push_exp("t4_busy", 0); push_exp("t4_err_cnt", 0);
      push_exp("t4_done_cnt", 1);
      check(32'(state)); check(32'(busy)); check(err_seen); check(done_seen);
      // asynchronous reset during release
      fire = 1'b0;
      tick();
      angle = 20; velocity = 30; fire = 1'b1;
      repeat (A + S + 1) tick();
      push_exp("t5_arm", 1); push_exp("t5_state_rel", 3);
      check(32'(arm_release)); check(32'(state));
      #2 reset = 1'b1;
      #1;
      push_exp("t5_async_arm", 0); push_exp("t5_async_motor", 0); push_exp("t5_async_state", 0);
      push_exp("t5_async_busy", 0);
      check(32'(arm_release)); check(32'(motor_cmd)); check(32'(state)); check(32'(busy));
      @(negedge clock);
      reset = 1'b0;
      repeat (3) tick();
      push_exp("t5_no_relaunch", 0);
      check(32'(state));
      fire = 1'b0; tick();
      fire = 1'b1; tick();
      push_exp("t5_relaunch_state", 1); push_exp("t5_relaunch_theta", 20);
      check(32'(state)); check(32'(theta_cmd));
      abort = 1'b1; tick();
      abort = 1'b0;
      repeat (C) tick();
      push_exp("t5_end_state", 0);
      check(32'(state));
      // abort beats a same-cycle fire edge in IDLE
      fire = 1'b0;
      tick();
      angle = 10; velocity = 10; fire = 1'b1; abort = 1'b1;
      tick();
      push_exp("t6_state", 0); push_exp("t6_err", 0); push_exp("t6_busy", 0);
      check(32'(state)); check(32'(err)); check(32'(busy));
      abort = 1'b0;
      tick();
      push_exp("t6_no_late_launch", 0);
      check(32'(state));
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: observed %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
